// File: rtl/mem_port_arbiter.sv
// Two-requester (I fetch / D load-store) arbiter in front of one single-port memory.
// Optional memory timeout enabled with `define ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic                  d_mode,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_mode,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  owner,
  output logic                  err
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  if (MAX_D_STREAK < 1 || TIMEOUT < 1) begin : g_param_check
    $error("mem_port_arbiter: MAX_D_STREAK and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state, state_nxt;
  logic                  mem_req_nxt, mem_we_nxt, mem_mode_nxt, owner_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
  logic                  i_ack_nxt, d_ack_nxt, err_nxt;
  logic [SW-1:0]         streak, streak_nxt;
  logic                  grant_d;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT);
  logic [TW-1:0] wait_cnt, wait_cnt_nxt;
`endif

  // D wins unless I has been passed over MAX_D_STREAK times in a row
  assign grant_d = d_req && !(i_req && streak == STREAK_MAX);

  always_comb begin
    state_nxt     = state;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_mode_nxt  = mem_mode;
    owner_nxt     = owner;
    i_rdata_nxt   = i_rdata;
    d_rdata_nxt   = d_rdata;
    streak_nxt    = streak;
    i_ack_nxt     = 1'b0;
    d_ack_nxt     = 1'b0;
    err_nxt       = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wait_cnt_nxt  = wait_cnt;
`endif
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt     = BUSY;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          mem_mode_nxt  = d_mode;
          owner_nxt     = 1'b1;
          if (!i_req)                    streak_nxt = '0;
          else if (streak != STREAK_MAX) streak_nxt = streak + SW'(1);
        end else if (i_req) begin
          state_nxt     = BUSY;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = i_addr;
          mem_wdata_nxt = '0;
          mem_mode_nxt  = 1'b0;
          owner_nxt     = 1'b0;
          streak_nxt    = '0;
        end
`ifdef ARB_TIMEOUT_EN
        wait_cnt_nxt = '0;
`endif
      end
      BUSY: begin
        if (mem_ack) begin
          state_nxt   = RESP;
          mem_req_nxt = 1'b0;
          if (owner) begin d_rdata_nxt = mem_rdata; d_ack_nxt = 1'b1; end
          else       begin i_rdata_nxt = mem_rdata; i_ack_nxt = 1'b1; end
        end
`ifdef ARB_TIMEOUT_EN
        else if (wait_cnt == TO_LIM) begin
          state_nxt   = RESP;
          mem_req_nxt = 1'b0;
          err_nxt     = 1'b1;
          if (owner) begin d_rdata_nxt = '0; d_ack_nxt = 1'b1; end
          else       begin i_rdata_nxt = '0; i_ack_nxt = 1'b1; end
        end else begin
          wait_cnt_nxt = wait_cnt + TW'(1);
        end
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_mode  <= 1'b0;
      owner     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      err       <= 1'b0;
      streak    <= '0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_mode  <= mem_mode_nxt;
      owner     <= owner_nxt;
      i_rdata   <= i_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      i_ack     <= i_ack_nxt;
      d_ack     <= d_ack_nxt;
      err       <= err_nxt;
      streak    <= streak_nxt;
`ifdef ARB_TIMEOUT_EN
      wait_cnt  <= wait_cnt_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run scored against a word-array memory model and the arbitration rule.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_mode = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_ack, d_ack, mem_req, mem_we, mem_mode, owner, err;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] pmem    [1024];
  logic [DW-1:0] ref_mem [1024];
  int mem_wait = 0;   // -1: never ack, -2: random 0..3 waits
  int cur_wait = 0;
  int mcnt = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mode(d_mode),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mode(mem_mode), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  // Memory model: reacts to registered DUT outputs on the falling edge
  always @(negedge clk) begin
    if (mem_req && mem_wait != -1) begin
      if (mcnt == cur_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = pmem[mem_addr[9:0]];
        if (mem_we) pmem[mem_addr[9:0]] = mem_wdata;
        mcnt = 0;
      end else begin
        mem_ack = 1'b0;
        mcnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      mcnt     = 0;
      cur_wait = (mem_wait == -2) ? int'($urandom_range(0, 3)) : mem_wait;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_mode, i_ack, d_ack, owner, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {mem_req, mem_we, mem_mode, i_ack, d_ack, owner, err});
    end
    checks++;
    if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h expected all zero", mem_addr, mem_wdata, i_rdata, d_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_i_basic();
    @(negedge clk);
    mem_wait = 0;
    pmem[10'h100] = 32'h13; ref_mem[10'h100] = 32'h13;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || owner !== 1'b0) begin
      errors++;
      $display("FAIL i_basic_grant: got req=%b addr=%h we=%b owner=%b expected 1 100 0 0", mem_req, mem_addr, mem_we, owner);
    end
    @(negedge clk);
    checks++;
    if (i_ack !== 1'b1 || i_rdata !== 32'h13 || d_ack !== 1'b0) begin
      errors++;
      $display("FAIL i_basic_ack: got i_ack=%b i_rdata=%h d_ack=%b expected 1 13 0", i_ack, i_rdata, d_ack);
    end
    i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (i_ack !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL i_basic_pulse: got i_ack=%b mem_req=%b expected 0 0", i_ack, mem_req);
    end
  endtask

  task automatic test_d_store_wait();
    int pulses = 0;
    @(negedge clk);
    mem_wait = 3;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_mode = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2004 ||
            mem_wdata !== 32'hDEADBEEF || mem_mode !== 1'b1 || owner !== 1'b1) begin
          errors++;
          $display("FAIL d_store_hold c=%0d: got req=%b we=%b addr=%h wdata=%h mode=%b expected 1 1 2004 deadbeef 1",
                   c, mem_req, mem_we, mem_addr, mem_wdata, mem_mode);
        end
      end
      if (c == 5) begin
        checks++;
        if (d_ack !== 1'b1 || i_ack !== 1'b0) begin
          errors++;
          $display("FAIL d_store_ack: got d_ack=%b i_ack=%b at cycle 5 expected 1 0", d_ack, i_ack);
        end
      end
      if (d_ack === 1'b1) begin
        pulses++;
        d_req = 1'b0;
        ref_mem[10'h004] = 32'hDEADBEEF;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL d_store_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic got [10];
    int   gcyc[10];
    int   ng = 0, c = 0, run = 0;
    logic prev = 1'b0, exp_d;
    @(negedge clk);
    mem_wait = 0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_mode = 1'b0; d_wdata = '0;
    while (ng < 10 && c < 200) begin
      @(negedge clk);
      c++;
      if (mem_req && !prev) begin
        got[ng] = owner; gcyc[ng] = c; ng++;
      end
      prev = mem_req;
    end
    checks++;
    if (ng < 10) begin
      errors++;
      $display("FAIL streak_timeout: got %0d grants expected 10", ng);
    end else begin
      for (int k = 0; k < 10; k++) begin
        exp_d = (run != MAXS);
        run = exp_d ? run + 1 : 0;
        checks++;
        if (got[k] !== exp_d) begin
          errors++;
          $display("FAIL streak_grant %0d: got owner=%b expected %b", k, got[k], exp_d);
        end
        if (k > 0) begin
          checks++;
          if (gcyc[k] - gcyc[k-1] != 3) begin
            errors++;
            $display("FAIL back_to_back %0d: got spacing %0d expected 3", k, gcyc[k] - gcyc[k-1]);
          end
        end
      end
    end
    c = 0;
    while ((i_req || d_req) && c < 50) begin
      @(negedge clk);
      c++;
      if (i_ack) i_req = 1'b0;
      if (d_ack && !i_req) d_req = 1'b0;
    end
    checks++;
    if (i_req || d_req) begin
      errors++;
      $display("FAIL streak_drain: got i_req=%b d_req=%b expected both released", i_req, d_req);
      i_req = 1'b0; d_req = 1'b0;
    end
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    mem_wait = -1;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_grant: got mem_req=%b expected 1", mem_req);
    end
    @(negedge clk);
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0 || owner !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_clear: got req=%b i_ack=%b d_ack=%b owner=%b expected 0 0 0 0", mem_req, i_ack, d_ack, owner);
    end
    rst = 1'b0; mem_wait = 0;
    @(negedge clk);
    i_req = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL rst_busy_regrant: got req=%b addr=%h expected 1 40", mem_req, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (i_ack !== 1'b1 || i_rdata !== ref_mem[10'h040]) begin
      errors++;
      $display("FAIL rst_busy_ack: got i_ack=%b rdata=%h expected 1 %h", i_ack, i_rdata, ref_mem[10'h040]);
    end
    i_req = 1'b0;
  endtask

  task automatic test_timeout();
    int early = 0;
    @(negedge clk);
    mem_wait = -1;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_mode = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (d_ack || err) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early: got %0d early ack/err cycles expected 0", early);
    end
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b1 || err !== 1'b1 || d_rdata !== '0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_resp: got d_ack=%b err=%b d_rdata=%h mem_req=%b expected 1 1 0 0", d_ack, err, d_rdata, mem_req);
    end
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || d_ack !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_clear: got err=%b d_ack=%b expected 0 0", err, d_ack);
    end
`else
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (d_ack || err) early++;
    end
    checks++;
    if (early != 0 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout_wait: got %0d ack cycles mem_req=%b expected 0 1", early, mem_req);
    end
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
`endif
    mem_wait = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int   dcount = 0, cyc = 0, acks = 0;
    logic pi = 1'b0, pd = 1'b0, prev = 1'b0, exp_d, done = 1'b0;
    @(negedge clk);
    mem_wait = -2;
    @(negedge clk);
    prev = mem_req;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (mem_req && !prev) begin
        exp_d = pd && !(pi && dcount == MAXS);
        dcount = (exp_d && pi) ? dcount + 1 : 0;
        checks++;
        if (owner !== exp_d) begin
          errors++;
          $display("FAIL rand_owner cyc=%0d: got %b expected %b", cyc, owner, exp_d);
        end
        checks++;
        if (exp_d && (mem_addr !== d_addr || mem_we !== d_we || mem_wdata !== d_wdata || mem_mode !== d_mode)) begin
          errors++;
          $display("FAIL rand_d_fields cyc=%0d: got %h %b %h %b expected %h %b %h %b",
                   cyc, mem_addr, mem_we, mem_wdata, mem_mode, d_addr, d_we, d_wdata, d_mode);
        end else if (!exp_d && (mem_addr !== i_addr || mem_we !== 1'b0 || mem_wdata !== '0 || mem_mode !== 1'b0)) begin
          errors++;
          $display("FAIL rand_i_fields cyc=%0d: got %h %b %h %b expected %h 0 0 0",
                   cyc, mem_addr, mem_we, mem_wdata, mem_mode, i_addr);
        end
      end
      prev = mem_req;
      if (i_ack && d_ack) begin
        checks++; errors++;
        $display("FAIL rand_both_ack cyc=%0d: got both acks expected one", cyc);
      end
      if (i_ack) begin
        acks++;
        checks++;
        if (!pi || i_rdata !== ref_mem[i_addr[9:0]] || err !== 1'b0) begin
          errors++;
          $display("FAIL rand_i_ack cyc=%0d: got rdata=%h req=%b err=%b expected %h 1 0", cyc, i_rdata, pi, err, ref_mem[i_addr[9:0]]);
        end
        i_req  = (cyc < 3000) ? 1'($urandom_range(0, 1)) : 1'b0;
        i_addr = 32'($urandom_range(0, 1023));
      end
      if (d_ack) begin
        acks++;
        checks++;
        if (!pd || err !== 1'b0 || (!d_we && d_rdata !== ref_mem[d_addr[9:0]])) begin
          errors++;
          $display("FAIL rand_d_ack cyc=%0d: got rdata=%h req=%b err=%b expected %h 1 0", cyc, d_rdata, pd, err, ref_mem[d_addr[9:0]]);
        end
        if (d_we) ref_mem[d_addr[9:0]] = d_wdata;
        d_req   = (cyc < 3000) ? 1'($urandom_range(0, 1)) : 1'b0;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'($urandom_range(0, 1023));
        d_wdata = $urandom;
        d_mode  = 1'($urandom_range(0, 1));
      end
      if (cyc < 3000 && !i_req && $urandom_range(0, 3) == 0) begin
        i_req = 1'b1; i_addr = 32'($urandom_range(0, 1023));
      end
      if (cyc < 3000 && !d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = 32'($urandom_range(0, 1023));
        d_wdata = $urandom; d_mode = 1'($urandom_range(0, 1));
      end
      if (cyc >= 3000 && !i_req && !d_req) done = 1'b1;
      pi = i_req; pd = d_req;
    end
    checks++;
    if (!done || acks < 100) begin
      errors++;
      $display("FAIL rand_progress: got done=%b acks=%0d expected 1 and >=100", done, acks);
    end
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) begin
      pmem[k]    = (32'(k) * 32'h01010101) ^ 32'h5A5A0000;
      ref_mem[k] = pmem[k];
    end
    test_reset();
    test_i_basic();
    test_d_store_wait();
    test_back_to_back();
    test_reset_busy();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
